// File: rtl/hazard_sched_if.sv
// Hazard scheduler bundle: pipeline hazard inputs and stage control outputs.
// master = pipeline datapath side, slave = scheduler side.
interface hazard_sched_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        mem_busy;

  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_write;
  logic        idex_bubble;
  logic        exmem_hold;
  logic        mem_timeout;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt,
    output ex_memread, ex_rt, ex_branch_taken,
    output mem_busy,
    input  pc_write, ifid_write, ifid_flush,
    input  idex_write, idex_bubble, exmem_hold,
    input  mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt,
    input  ex_memread, ex_rt, ex_branch_taken,
    input  mem_busy,
    output pc_write, ifid_write, ifid_flush,
    output idex_write, idex_bubble, exmem_hold,
    output mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sched.sv
// Load-use / branch-flush / memory-freeze scheduler for the 5-stage core.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_sched #(
  parameter int BR_PENALTY   = 1,
  parameter int MAX_MEM_WAIT = 15
) (
  input logic           clk,
  input logic           rst,
  hazard_sched_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [2:0] BR_INIT  = 3'(BR_PENALTY - 1);
  localparam logic [7:0] WAIT_LIM = 8'(MAX_MEM_WAIT - 1);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  state_e     eff_state;
  logic [2:0] br_cnt_q, br_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       tmo_q, tmo_d;
  logic       load_use;
  logic       tmo_hit;
  logic       stall_act;

  logic pc_w, ifid_w, ifid_f;
  logic idex_w, idex_b, hold;

  assign load_use = bus.id_valid
                  & bus.ex_memread
                  & (bus.ex_rt != 5'd0)
                  & ((bus.ex_rt == bus.id_rs)
                   | (bus.id_uses_rt
                    & (bus.ex_rt == bus.id_rt)));

  // Leaving MEM_WAIT acts as the saved state within the same cycle.
  assign eff_state =
    (state_q == MEM_WAIT && !bus.mem_busy)
      ? ret_q : state_q;

  assign tmo_hit = bus.mem_busy
                 & (wait_cnt_q == WAIT_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      ret_q      <= RUN;
      br_cnt_q   <= 3'd0;
      wait_cnt_q <= 8'd0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      br_cnt_q   <= br_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    br_cnt_d = br_cnt_q;
    if (bus.mem_busy) begin
      state_d = MEM_WAIT;
      if (state_q != MEM_WAIT) ret_d = state_q;
    end else begin
      unique case (eff_state)
        RUN: begin
          state_d = RUN;
          if (bus.ex_branch_taken && BR_PENALTY > 1) begin
            state_d  = BR_FLUSH;
            br_cnt_d = BR_INIT;
          end
        end
        BR_FLUSH: begin
          br_cnt_d = br_cnt_q - 3'd1;
          state_d  = (br_cnt_q == 3'd1)
                   ? RUN : BR_FLUSH;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    wait_cnt_d = 8'd0;
    if (bus.mem_busy)
      wait_cnt_d = (wait_cnt_q == 8'hFF)
                 ? wait_cnt_q
                 : wait_cnt_q + 8'd1;
    tmo_d = tmo_q | tmo_hit;
  end

  always_comb begin
    pc_w      = 1'b1;
    ifid_w    = 1'b1;
    ifid_f    = 1'b0;
    idex_w    = 1'b1;
    idex_b    = 1'b0;
    hold      = 1'b0;
    stall_act = 1'b0;
    priority case (1'b1)
      rst: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        idex_w = 1'b0;
        ifid_f = 1'b1;
        idex_b = 1'b1;
      end
      bus.mem_busy: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        idex_w = 1'b0;
        hold   = 1'b1;
      end
      (eff_state == BR_FLUSH),
      bus.ex_branch_taken: begin
        ifid_f = 1'b1;
        idex_b = 1'b1;
      end
      load_use: begin
        pc_w      = 1'b0;
        ifid_w    = 1'b0;
        idex_b    = 1'b1;
        stall_act = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pc_write    = pc_w;
  assign bus.ifid_write  = ifid_w;
  assign bus.ifid_flush  = ifid_f;
  assign bus.idex_write  = idex_w;
  assign bus.idex_bubble = idex_b;
  assign bus.exmem_hold  = hold;
  assign bus.mem_timeout = ~rst
                         & (tmo_q | tmo_hit);

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_act && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (ifid_f && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = 16'd0;
  assign bus.flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: directed hazards plus random traffic.
// Expected controls come from a cycle-level behavioural model.
module tb_hazard_sched;
  localparam int P  = 3;
  localparam int MW = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_sched_if bus ();

  hazard_sched #(
    .BR_PENALTY   (P),
    .MAX_MEM_WAIT (MW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [5:0]  ctl;
    logic        tmo;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  event  drv_ev;
  int    checks = 0;
  int    passed = 0;

  int flush_rem = 0;
  int busy_run  = 0;
  bit m_tmo     = 0;
  int m_sc      = 0;
  int m_fc      = 0;

  // ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_hold}
  localparam logic [5:0] C_RST   = 6'b001010;
  localparam logic [5:0] C_RUN   = 6'b110100;
  localparam logic [5:0] C_FRZ   = 6'b000001;
  localparam logic [5:0] C_FLUSH = 6'b111110;
  localparam logic [5:0] C_STALL = 6'b000110;

  task automatic step(
    input bit r, input bit v,
    input logic [4:0] rs, input logic [4:0] rt,
    input bit urt, input bit mr,
    input logic [4:0] ert, input bit br,
    input bit mb, input string nm);
    exp_t e;
    bit   lu;
    @(negedge clk);
    rst                 = r;
    bus.id_valid        = v;
    bus.id_rs           = rs;
    bus.id_rt           = rt;
    bus.id_uses_rt      = urt;
    bus.ex_memread      = mr;
    bus.ex_rt           = ert;
    bus.ex_branch_taken = br;
    bus.mem_busy        = mb;
    lu = v && mr && ert != 0 &&
         (ert == rs || (urt && ert == rt));
    if (r) begin
      flush_rem = 0;
      busy_run  = 0;
      m_tmo     = 0;
      m_sc      = 0;
      m_fc      = 0;
      e.ctl     = C_RST;
    end else if (mb) begin
      busy_run++;
      if (busy_run >= MW) m_tmo = 1;
      e.ctl = C_FRZ;
    end else begin
      busy_run = 0;
      if (flush_rem > 0) begin
        e.ctl = C_FLUSH;
        flush_rem--;
      end else if (br) begin
        e.ctl     = C_FLUSH;
        flush_rem = P - 1;
      end else if (lu) begin
        e.ctl = C_STALL;
      end else begin
        e.ctl = C_RUN;
      end
    end
    e.tmo = m_tmo;
`ifdef HAZARD_PERF_EN
    e.sc = 16'(m_sc);
    e.fc = 16'(m_fc);
    if (!r && e.ctl == C_STALL && m_sc < 65535) m_sc++;
    if (!r && e.ctl == C_FLUSH && m_fc < 65535) m_fc++;
`else
    e.sc = 16'd0;
    e.fc = 16'd0;
`endif
    exp_q.push_back(e);
    name_q.push_back(nm);
    -> drv_ev;
  endtask

  task automatic chk(input string nm, input string what,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s %s: got %h want %h",
                  nm, what, got, want);
  endtask

  initial begin
    exp_t  e;
    string nm;
    logic [5:0] ctl;
    forever begin
      @(drv_ev);
      #2;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      ctl = {bus.pc_write, bus.ifid_write,
             bus.ifid_flush, bus.idex_write,
             bus.idex_bubble, bus.exmem_hold};
      chk(nm, "ctl", 32'(ctl), 32'(e.ctl));
      chk(nm, "mem_timeout",
          32'(bus.mem_timeout), 32'(e.tmo));
      chk(nm, "counters",
          {bus.stall_cnt, bus.flush_cnt},
          {e.sc, e.fc});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int burst;
    bus.id_valid        = 0;
    bus.id_rs           = 0;
    bus.id_rt           = 0;
    bus.id_uses_rt      = 0;
    bus.ex_memread      = 0;
    bus.ex_rt           = 0;
    bus.ex_branch_taken = 0;
    bus.mem_busy        = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    step(1, 1, 5, 0, 0, 1, 5, 1, 0, "reset_inputs");

    step(0, 1, 5, 0, 0, 1, 5, 0, 0, "load_use");
    step(0, 1, 5, 0, 0, 0, 5, 0, 0, "lu_release");
    step(0, 1, 0, 0, 0, 1, 0, 0, 0, "zero_reg");
    step(0, 1, 3, 7, 0, 1, 7, 0, 0, "rt_unused");
    step(0, 1, 3, 7, 1, 1, 7, 0, 0, "rt_used");
    step(0, 0, 5, 0, 0, 1, 5, 0, 0, "id_invalid");

    step(0, 1, 5, 0, 0, 1, 5, 1, 0, "br_lu");
    step(0, 1, 5, 0, 0, 1, 5, 0, 0, "br_flush2");
    step(0, 1, 5, 0, 0, 1, 5, 1, 0, "br_flush3");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "br_done");

    step(0, 0, 0, 0, 0, 0, 0, 1, 0, "brm_flush1");
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, "brm_freeze");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "brm_flush2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "brm_flush3");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "brm_done");

    step(0, 0, 0, 0, 0, 0, 0, 1, 1, "br_frozen");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, "br_after_wait");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "baw_flush2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "baw_flush3");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "baw_done");

    for (int i = 0; i < 14; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, "wd_busy14");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "wd_14_idle");
    for (int i = 0; i < 15; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, "wd_busy15");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "wd_sticky");
    step(0, 1, 5, 0, 0, 1, 5, 0, 0, "wd_sticky_lu");

    step(0, 0, 0, 0, 0, 0, 0, 1, 0, "rst_br");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_flush2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst_mid_flush");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_release");
    step(0, 1, 2, 0, 0, 1, 2, 0, 0, "rst_then_lu");

    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      bit mb;
      if (burst == 0 && $urandom_range(0, 15) == 0)
        burst = $urandom_range(1, 20);
      mb = (burst > 0);
      if (burst > 0) burst--;
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)),
           $urandom_range(0, 9) == 0,
           mb, "random");
    end

    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d want 0",
                  exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
Pipeline hazard scheduler for the 5-stage MIPS core. It drives the write-enable, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM stages.
- Resolves load-use stalls.
- Flushes the pipeline on a taken branch, with a configurable penalty.
- Freezes the whole pipe while data memory is busy, with a watchdog on the wait.
- idex_bubble connects directly to the ID/EX register's HazardMUX (zeroing) input.

Parameters:
BR_PENALTY, 1, cycles of IF/ID + ID/EX flush per taken branch (legal 1..4)
MAX_MEM_WAIT, 15, consecutive mem_busy cycles before mem_timeout sets (legal 1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  ID stage holds a real instruction
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_memread  in  1  instruction in EX is a load
ex_rt  in  5  destination register of the load in EX
ex_branch_taken  in  1  branch in EX resolved taken
mem_busy  in  1  data memory not ready this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear
idex_write  out  1  ID/EX load enable
idex_bubble  out  1  ID/EX zero-insert (HazardMUX)
exmem_hold  out  1  EX/MEM and MEM/WB hold
mem_timeout  out  1  sticky watchdog flag
stall_cnt  out  16  load-use stall cycles (optional feature)
flush_cnt  out  16  branch flush cycles (optional feature)

Behaviour:
- Reset is asynchronous, active-high on rst; clock is clk.
- While rst=1:
  - state=RUN; br_cnt=0; wait_cnt=0; ret_state=RUN; mem_timeout=0; counters=0.
  - Outputs forced: pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, idex_bubble=1, exmem_hold=0.
- FSM states: RUN, BR_FLUSH, MEM_WAIT. Outputs are combinational from state and inputs (Mealy), so every response takes effect in the same cycle as its cause. All state changes occur on the clk rising edge.
- Default outputs (RUN, no event): pc_write=1, ifid_write=1, idex_write=1, ifid_flush=0, idex_bubble=0, exmem_hold=0.
- Event priority: mem_busy > ex_branch_taken > load-use.
- Load-use condition: id_valid & ex_memread & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
  - In RUN: pc_write=0, ifid_write=0, idex_bubble=1.
  - Stall lasts 1 cycle; the state stays RUN.
- Taken branch in RUN:
  - ifid_flush=1, idex_bubble=1, pc_write=1; any load-use condition is ignored.
  - If BR_PENALTY>1: next state BR_FLUSH, br_cnt=BR_PENALTY-1.
- BR_FLUSH:
  - Outputs as for the taken branch; ex_branch_taken and load-use are ignored.
  - br_cnt decrements each cycle; when br_cnt==1 the next state is RUN.
  - Total flush cycles per branch = BR_PENALTY.
- mem_busy=1 in any state:
  - Outputs: pc_write=0, ifid_write=0, idex_write=0, ifid_flush=0, idex_bubble=0, exmem_hold=1.
  - On entry from RUN or BR_FLUSH, ret_state captures the current state and br_cnt is held.
  - Next state: MEM_WAIT.
- MEM_WAIT:
  - Same freeze outputs while mem_busy=1.
  - When mem_busy=0: return to ret_state; that state's outputs apply in this same cycle.
  - A frozen taken branch is therefore serviced after the wait, and BR_FLUSH resumes with its held count.
- Watchdog:
  - wait_cnt (8 bit, saturating) increments each cycle mem_busy=1 and clears when mem_busy=0.
  - mem_timeout sets when wait_cnt reaches MAX_MEM_WAIT-1 while mem_busy=1, i.e. on the MAX_MEM_WAIT-th consecutive busy cycle.
  - mem_timeout clears only on rst.
- Reset mid-operation (e.g. during BR_FLUSH or MEM_WAIT) aborts immediately to the reset values.

Optional Feature:
HAZARD_PERF_EN:
- Defined:
  - stall_cnt increments on each cycle where the load-use stall is applied.
  - flush_cnt increments on each cycle with ifid_flush=1 outside reset.
  - Both are 16-bit, saturating at 0xFFFF, and cleared by rst.
- Undefined: both ports remain present and are tied to 0; no counter flops are synthesized.

Test Plan:
- Load-use: ex_memread=1, ex_rt=5, id_rs=5, id_valid=1 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; next cycle (ex_memread=0) defaults restored; stall_cnt=1 if enabled.
- Zero register: ex_memread=1, ex_rt=0, id_rs=0 -> no stall; id_uses_rt=0 with ex_rt==id_rt=7 -> no stall.
- Branch, BR_PENALTY=3: ex_branch_taken=1 for one cycle with a coincident load-use -> ifid_flush=1 and idex_bubble=1 for exactly 3 cycles, pc_write=1 throughout, then RUN; flush_cnt=3 if enabled.
- mem_busy asserted for 4 cycles during the 2nd BR_FLUSH cycle (BR_PENALTY=3) -> 4 frozen cycles with exmem_hold=1 and all writes 0, then the remaining flush cycles complete (3 flush cycles total).
- Watchdog, MAX_MEM_WAIT=15: mem_busy held 14 cycles -> mem_timeout=0; held 15 cycles -> mem_timeout=1 on the 15th and remains 1 after mem_busy drops, until rst.
- Asynchronous rst pulse mid-BR_FLUSH -> outputs take reset values immediately without a clock edge; after release, RUN defaults apply with br_cnt=0.
